// File: rtl/ccd_line_framer_pkg.sv
// rtl/ccd_line_framer_pkg.sv - shared types and constants for the CCD line framer
package ccd_line_framer_pkg;

  localparam int PIX_W_DEF = 12;

  // Line region the framer is currently counting pixels in
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_DARK,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  // FIFO entry is {sol, eol, corrected pixel}
  function automatic int entry_w(input int pix_w);
    return pix_w + 2;
  endfunction

endpackage

// File: rtl/ccd_line_framer_if.sv
// rtl/ccd_line_framer_if.sv - pixel input and framed output stream bundle
interface ccd_line_framer_if #(
  parameter int PIX_W = 12
);
  logic [PIX_W-1:0] pixel_data;
  logic             pixel_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_sol;
  logic             out_eol;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output pixel_data, pixel_valid, out_ready,
    input  out_data, out_sol, out_eol, out_valid
  );

  modport slave (
    input  pixel_data, pixel_valid, out_ready,
    output out_data, out_sol, out_eol, out_valid
  );
endinterface

// File: rtl/ccd_line_framer_pix_fifo.sv
// rtl/ccd_line_framer_pix_fifo.sv - synchronous first-word-fall-through FIFO
module pix_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A write into a full FIFO is only taken when a read frees a slot that cycle
  always_comb begin
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!do_wr && do_rd) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/ccd_line_framer.sv
// rtl/ccd_line_framer.sv - frames ADC pixels into dark-corrected CCD lines
module ccd_line_framer
  import ccd_line_framer_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int DUMMY_PIX  = 16,
  parameter int DARK_PIX   = 16,
  parameter int ACTIVE_PIX = 2048,
  parameter int FIFO_DEPTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rog,
  ccd_line_framer_if.slave   bus,
  output logic [PIX_W-1:0]   dark_level,
  output logic [15:0]        line_count,
  output logic               ovf,
  output logic               trunc,
  input  logic               status_clr
);
  localparam int DARK_SH = $clog2(DARK_PIX);
  localparam int SUM_W   = PIX_W + DARK_SH;
  localparam int CNT_W   = $clog2(DUMMY_PIX + DARK_PIX + ACTIVE_PIX + 1);
  localparam int ENT_W   = entry_w(PIX_W);

  state_e             state_q, state_d, st;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_next;
  logic [PIX_W-1:0]   dark_q, dark_d, corr;
  logic               rog_q, rog_d, rog_edge;
  logic [15:0]        line_q, line_d;
  logic               stg_vld_q, stg_vld_d;
  logic [ENT_W-1:0]   stg_data_q, stg_data_d;
  logic               ovf_q, ovf_d, trunc_q, trunc_d;
  logic               ovf_set, trunc_set;
  logic               fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [ENT_W-1:0]   fifo_dout;

  // Line framing: region tracking, dark averaging and the registered subtract.
  // A ROG edge restarts the line before the current pixel is classified, so a
  // pixel arriving with the edge becomes pixel 0 of the new line. dark_q is
  // always settled before the first active pixel because the last dark pixel
  // and the first active pixel can never be accepted in the same cycle.
  always_comb begin
    rog_d      = rog;
    rog_edge   = rog & ~rog_q;
    st         = rog_edge ? ST_DUMMY : state_q;
    cnt        = rog_edge ? '0 : cnt_q;
    state_d    = st;
    cnt_d      = cnt;
    sum_d      = sum_q;
    dark_d     = dark_q;
    line_d     = line_q + {15'd0, rog_edge};
    stg_vld_d  = 1'b0;
    stg_data_d = stg_data_q;
    trunc_set  = rog_edge & ((state_q == ST_DUMMY) | (state_q == ST_DARK) |
                             (state_q == ST_ACTIVE));
    sum_next   = ((cnt == '0) ? '0 : sum_q) + {{DARK_SH{1'b0}}, bus.pixel_data};
    corr       = (bus.pixel_data > dark_q) ? bus.pixel_data - dark_q : '0;
    if (bus.pixel_valid) begin
      case (st)
        ST_DUMMY: begin
          if (cnt == CNT_W'(DUMMY_PIX - 1)) begin
            state_d = ST_DARK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_DARK: begin
          sum_d = sum_next;
          if (cnt == CNT_W'(DARK_PIX - 1)) begin
            dark_d  = sum_next[SUM_W-1 -: PIX_W];
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          stg_vld_d  = 1'b1;
          stg_data_d = {cnt == '0, cnt == CNT_W'(ACTIVE_PIX - 1), corr};
          if (cnt == CNT_W'(ACTIVE_PIX - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky status: a new event in the same cycle as status_clr keeps the flag set
  always_comb begin
    fifo_rd = bus.out_ready & ~fifo_empty;
    fifo_wr = stg_vld_q;
    ovf_set = stg_vld_q & fifo_full & ~fifo_rd;
    ovf_d   = ovf_set | (ovf_q & ~status_clr);
    trunc_d = trunc_set | (trunc_q & ~status_clr);
  end

  // State and datapath registers; rog_q starts high so a held ROG is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      dark_q     <= '0;
      rog_q      <= 1'b1;
      line_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      ovf_q      <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      dark_q     <= dark_d;
      rog_q      <= rog_d;
      line_q     <= line_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      ovf_q      <= ovf_d;
      trunc_q    <= trunc_d;
    end
  end

  pix_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (fifo_wr),
    .din   (stg_data_q),
    .full  (fifo_full),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Output fields are forced to 0 while empty so the stale RAM word never shows
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_dout[PIX_W-1:0];
  assign bus.out_sol   = ~fifo_empty & fifo_dout[PIX_W+1];
  assign bus.out_eol   = ~fifo_empty & fifo_dout[PIX_W];
  assign dark_level    = dark_q;
  assign line_count    = line_q;
  assign ovf           = ovf_q;
  assign trunc         = trunc_q;
endmodule
